// File: rtl/dtw_ref_streamer.sv
// Read-side sequencer streaming reference samples from BRAM as valid/ready.
// Optional DTW_REF_LOOP_EN adds a loop input for back-to-back repeated passes.
module dtw_ref_streamer #(
    parameter int width  = 16,
    parameter int ptrWid = 15,
    parameter int depth  = 2**ptrWid
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ptrWid:0]   ref_len,
`ifdef DTW_REF_LOOP_EN
    input  logic              loop,
`endif
    output logic [ptrWid-1:0] addrR,
    input  logic [width-1:0]  mem_data,
    output logic [width-1:0]  ref_data,
    output logic              ref_valid,
    input  logic              ref_ready,
    output logic              ref_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [ptrWid:0] DEPTH_L = (ptrWid+1)'(depth);

    state_t            state_q, state_d;
    logic [ptrWid:0]   len_q, len_d;
    logic [ptrWid:0]   issued_q, issued_d;
    logic [ptrWid-1:0] addr_q, addr_d;
    logic              infl_q, infl_d;
    logic              ilast_q, ilast_d;
    logic              ifin_q, ifin_d;
    logic [width-1:0]  bdat_q [2];
    logic [width-1:0]  bdat_d [2];
    logic [1:0]        blast_q, blast_d;
    logic [1:0]        bfin_q, bfin_d;
    logic              head_q, head_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [ptrWid:0]   len_clamp;
    logic [2:0]        occ;
    logic              pop, issue, is_last, loop_now, tail;

`ifdef DTW_REF_LOOP_EN
    assign loop_now = loop;
`else
    assign loop_now = 1'b0;
`endif

    assign len_clamp = (ref_len > DEPTH_L) ? DEPTH_L : ref_len;
    assign ref_valid = (cnt_q != 2'd0);
    assign ref_data  = bdat_q[head_q];
    assign ref_last  = ref_valid && blast_q[head_q];
    assign pop       = ref_valid && ref_ready;
    assign addrR     = addr_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);

    // Occupancy after this edge; counting the concurrent pop keeps one read per cycle.
    assign occ     = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign is_last = (issued_q == len_q - 1'b1);
    assign issue   = (state_q == RUN) && (issued_q < len_q) && (occ < 3'd2);
    assign tail    = head_q ^ (cnt_q == 2'd1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        infl_d   = issue;
        ilast_d  = ilast_q;
        ifin_d   = ifin_q;
        bdat_d   = bdat_q;
        blast_d  = blast_q;
        bfin_d   = bfin_q;
        head_d   = head_q;
        cnt_d    = cnt_q + {1'b0, infl_q} - {1'b0, pop};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len_clamp;
                    issued_d = '0;
                    addr_d   = '0;
                    state_d  = (len_clamp != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (pop && bfin_q[head_q]) state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            ilast_d = is_last;
            ifin_d  = is_last && !loop_now;
            if (is_last && loop_now) begin
                issued_d = '0;
                addr_d   = '0;
            end else begin
                issued_d = issued_q + 1'b1;
                // Hold on the final address so a full-depth pass never wraps.
                if (!is_last) addr_d = addr_q + 1'b1;
            end
        end

        if (infl_q) begin
            bdat_d[tail]  = mem_data;
            blast_d[tail] = ilast_q;
            bfin_d[tail]  = ifin_q;
        end

        if (pop) head_d = ~head_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            infl_q   <= 1'b0;
            ilast_q  <= 1'b0;
            ifin_q   <= 1'b0;
            bdat_q[0] <= '0;
            bdat_q[1] <= '0;
            blast_q  <= '0;
            bfin_q   <= '0;
            head_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            addr_q   <= addr_d;
            infl_q   <= infl_d;
            ilast_q  <= ilast_d;
            ifin_q   <= ifin_d;
            bdat_q   <= bdat_d;
            blast_q  <= blast_d;
            bfin_q   <= bfin_d;
            head_q   <= head_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// Bench for dtw_ref_streamer: BRAM model plus queue-based expected stream.
// Build with DTW_REF_LOOP_EN to also exercise the looping mode.
module tb_dtw_ref_streamer;

    localparam int W = 16;
    localparam int P = 6;
    localparam int D = 2**P;

    logic         clk = 1'b0;
    logic         rst, start, ref_ready;
    logic [P:0]   ref_len;
    logic [P-1:0] addrR;
    logic [W-1:0] mem_data, ref_data;
    logic         ref_valid, ref_last, busy, done;
`ifdef DTW_REF_LOOP_EN
    logic         loop;
`endif

    logic [W-1:0] mem [D];
    int checks = 0;
    int errors = 0;

    dtw_ref_streamer #(.width(W), .ptrWid(P), .depth(D)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ref_len(ref_len),
`ifdef DTW_REF_LOOP_EN
        .loop(loop),
`endif
        .addrR(addrR),
        .mem_data(mem_data),
        .ref_data(ref_data),
        .ref_valid(ref_valid),
        .ref_ready(ref_ready),
        .ref_last(ref_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[addrR];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    endtask

    // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_stream(input int rl, input int mode, input int npass,
                              input int start2_at);
        logic [W-1:0] q[$];
        bit           lq[$];
        logic [W-1:0] pdat;
        logic         plast;
        int n, total, got, last_hs_c, maxa;
        bit hs_done, pend, finished;
        n = (rl > D) ? D : rl;
        for (int p = 0; p < npass; p++)
            for (int i = 0; i < n; i++) begin
                q.push_back(mem[i]);
                lq.push_back(i == n - 1);
            end
        total = n * npass;
        got = 0; last_hs_c = 0; maxa = 0;
        hs_done = 0; pend = 0; finished = 0;
        pdat = '0; plast = 1'b0;
        start = 1'b1;
        ref_len = rl[P:0];
        tick();
        start = 1'b0;
        for (int c = 0; c < total * 4 + 20; c++) begin
            chk("busy", busy, (total > 0) && !hs_done);
            chk("done", done, (total == 0 && c == 0) ||
                              (hs_done && c == last_hs_c + 1));
            if (mode == 0 && total > 0)
                chk("valid_timing", ref_valid, c >= 2 && !hs_done);
            if (hs_done || total == 0)
                chk("valid_idle", ref_valid, 1'b0);
            if (pend) begin
                chk("hold_valid", ref_valid, 1'b1);
                chk("hold_data", ref_data, pdat);
                chk("hold_last", ref_last, plast);
            end
            if (!ref_valid) chk("last_no_valid", ref_last, 1'b0);
            if (int'(addrR) > maxa) maxa = int'(addrR);
            if ((hs_done && c == last_hs_c + 2) || (total == 0 && c == 1)) begin
                finished = 1;
                break;
            end
            case (mode)
                0: ref_ready = 1'b1;
                1: ref_ready = (c % 3 == 0);
                default: ref_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == start2_at) begin
                start = 1'b1;
                ref_len = 2;
            end else begin
                start = 1'b0;
                ref_len = rl[P:0];
            end
`ifdef DTW_REF_LOOP_EN
            loop = (npass > 1) && (c < npass * n - 1);
`endif
            pend = ref_valid && !ref_ready;
            pdat = ref_data;
            plast = ref_last;
            if (ref_valid && ref_ready) begin
                chk("no_extra_sample", got < total, 1'b1);
                if (q.size() > 0) begin
                    chk("data", ref_data, q.pop_front());
                    chk("last", ref_last, lq.pop_front());
                end
                got++;
                if (got == total) begin
                    hs_done = 1;
                    last_hs_c = c;
                end
            end
            tick();
        end
        start = 1'b0;
        ref_ready = 1'b0;
`ifdef DTW_REF_LOOP_EN
        loop = 1'b0;
`endif
        chk("completed", finished, 1'b1);
        chk("sample_count", got, total);
        if (n > 0) chk("max_addr", maxa, n - 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ref_len = '0;
        ref_ready = 1'b0;
`ifdef DTW_REF_LOOP_EN
        loop = 1'b0;
`endif
        for (int i = 0; i < D; i++) mem[i] = W'(i + 100);
        tick();
        tick();
        chk("rst_addr", addrR, 0);
        chk("rst_valid", ref_valid, 0);
        chk("rst_last", ref_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", ref_data, 0);
        rst = 1'b0;
        tick();

        run_stream(5, 0, 1, -1);
        fill_random();
        run_stream(8, 1, 1, -1);
        run_stream(12, 2, 1, -1);
        run_stream(0, 0, 1, -1);
        run_stream(1, 0, 1, -1);
        run_stream(D + 5, 2, 1, -1);
        run_stream(D, 0, 1, -1);
        run_stream(6, 0, 1, 3);
        run_stream(6, 1, 1, 4);

        // reset while sample 3 of a 10-sample pass is presented
        fill_random();
        start = 1'b1;
        ref_len = 10;
        tick();
        start = 1'b0;
        ref_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("pre_rst_data", ref_data, mem[3]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_addr", addrR, 0);
        chk("mid_rst_valid", ref_valid, 0);
        chk("mid_rst_last", ref_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", ref_data, 0);
        tick();
        chk("post_rst_valid", ref_valid, 0);
        ref_ready = 1'b0;
        run_stream(3, 0, 1, -1);

`ifdef DTW_REF_LOOP_EN
        fill_random();
        run_stream(3, 0, 3, -1);
        run_stream(5, 0, 2, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
